trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the commit stage and the M-mode CSR file.
- Arbitrates between synchronous exceptions and pending interrupts, and prioritises the winning cause.
- Updates mcause/mepc/mtval/mstatus for trap entry and MRET, then sequences the pipeline flush and PC redirect handshake.
- Owns mstatus.MIE/MPIE/MPP, mepc, mcause and mtval; mtvec is supplied externally.

Parameters:
XLEN, 32, datapath/CSR width
RESET_PC, 32'h0000_0000, unused internally; redirect targets come from mtvec_i/mepc only

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
commit_valid  input  1  instruction retiring this cycle (trap/interrupt decision point)
commit_pc  input  XLEN  PC of committing instruction
exc_cause  input  20  trap_cause_t one-hot-ish bit vector; nonzero = exception on committing instr
exc_tval  input  XLEN  faulting address/instruction for mtval
mret  input  1  committing instruction is MRET
mip  input  16  pending interrupt bits
mie  input  16  interrupt enable bits
mtvec  input  XLEN  trap vector (mode in [1:0])
flush  output  1  kill all in-flight instructions
flush_ack  input  1  pipeline drained
redirect_valid  output  1  new fetch PC valid
redirect_ready  input  1  fetch accepts redirect
redirect_pc  output  XLEN  new fetch PC
busy  output  1  trap sequence in progress; commit stage must stall
mstatus_mie / mstatus_mpie  output  1 each  current bits
mstatus_mpp  output  2  current MPP
mepc_o / mcause_o / mtval_o  output  XLEN each  current CSR values
csr_we  input  1  software CSR write strobe
csr_addr  input  12  0x300 mstatus, 0x341 mepc, 0x342 mcause, 0x343 mtval
csr_wdata  input  XLEN  write data

Behaviour:
- Reset (rst=1 at posedge): state IDLE; flush=0, redirect_valid=0, busy=0, redirect_pc=0; MIE=0, MPIE=0, MPP=2'b11; mepc=mcause=mtval=0.
- States: IDLE, FLUSH, REDIRECT.
- IDLE, commit_valid=1, evaluated in priority order:
  - exc_cause!=0 → exception. Code = priority encode in this order: BP, IPF, IAF, II, IAM, ECU, ECS, ECM, LAM, SAM, LPF, SPF, LAF, SAF; none matching → 0. mcause={0,code zero-extended}; mepc=commit_pc with [1:0] cleared; mtval=exc_tval.
  - else interrupt when MIE=1 and (mip&mie)!=0. Priority MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5) > COI(13). mcause={1,code}; mepc=commit_pc; mtval=0.
  - else mret=1 → MIE<=MPIE, MPIE<=1, MPP<=2'b11; target=mepc.
  - Exceptions beat interrupts on the same cycle.
- Trap entry also sets MPIE<=MIE, MIE<=0, MPP<=2'b11, all in the same edge as mcause/mepc/mtval. Target:
  - mtvec[1:0]==1 and interrupt → {mtvec[XLEN-1:2],2'b00} + 4*code.
  - otherwise → {mtvec[XLEN-1:2],2'b00}.
- On entry or MRET: next state FLUSH; busy=1 and flush=1 from the following cycle; redirect_pc latched.
- FLUSH: hold flush=1 until flush_ack=1 (sampled); then flush=0, go to REDIRECT. flush_ack in the first FLUSH cycle is allowed, giving a single-cycle flush.
- REDIRECT: redirect_valid=1, redirect_pc stable, until redirect_valid&redirect_ready; then IDLE, busy=0 the next cycle. Minimum trap latency: commit to redirect handshake = 3 cycles.
- While busy: commit_valid, mret, exc_cause, mip and csr_we are ignored; pending interrupts are re-evaluated only after returning to IDLE.
- CSR writes (IDLE only; a trap/MRET event on the same cycle wins and the write is dropped):
  - mstatus: only MIE(3), MPIE(7), MPP(12:11) are writable. MPP write values other than 2'b11 are coerced to 2'b11 (M-only).
  - mepc: bits [1:0] forced to 0.
  - mcause, mtval: full width.
  - Other addresses ignored.
- Reset mid-sequence returns to IDLE immediately and drops flush/redirect.

Test Plan:
- Reset → flush=0, redirect_valid=0, busy=0, MPP=2'b11, mepc=0, mcause=0.
- Illegal instruction: commit_pc=0x100, exc_cause bit2, exc_tval=0xDEAD, mtvec=0x800, MIE=1 → mcause=2, mepc=0x100, mtval=0xDEAD, MIE=0, MPIE=1, flush for ≥1 cycle, redirect_pc=0x800.
- Priority: exc_cause bits {BP,II,LAF} together → mcause=3. Exception and mip&mie=MTI on the same cycle → exception taken (mcause=bit31=0).
- Vectored interrupt: mtvec=0x801, MIE=1, mip=mie=(MTI|MEI) → mcause=0x8000000B, redirect_pc=0x82C, mepc=commit_pc.
- Interrupt masking: MIE=0, MTI pending and enabled → no trap, busy stays 0. Then csr write mstatus=0x8 → next commit traps with mcause=0x80000007.
- MRET: mepc=0x204, MPIE=1 → MIE=1, MPIE=1, redirect_pc=0x204. redirect_ready held 0 for 5 cycles → redirect_valid/redirect_pc stable, busy=1 throughout. Reset asserted in FLUSH → IDLE, flush=0 next cycle.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks exception/interrupt/MRET at commit, updates
// the M-mode trap CSRs, then runs the flush and redirect handshake with the pipeline.
module trap_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [19:0]     exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic [15:0]     mip,
    input  logic [15:0]     mie,
    input  logic [XLEN-1:0] mtvec,
    output logic            flush,
    input  logic            flush_ack,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            mstatus_mie,
    output logic            mstatus_mpie,
    output logic [1:0]      mstatus_mpp,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    state_t state_reg, state_next;

    logic            mie_reg, mpie_reg;
    logic [1:0]      mpp_reg;
    logic [XLEN-1:0] mepc_reg, mcause_reg, mtval_reg, redirect_pc_reg;

    logic            idle;
    logic            exc_take, irq_take, mret_take, event_take;
    logic [4:0]      exc_code;
    logic [3:0]      irq_code;
    logic            irq_any;
    logic [15:0]     pend;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_target;
    logic            unused_bits;

    assign idle = (state_reg == ST_IDLE);
    assign pend = mip & mie;

    // Exception code priority follows the privileged-spec ordering, not bit order.
    always_comb begin
        exc_code = 5'd0;
        if      (exc_cause[3])  exc_code = 5'd3;   // breakpoint
        else if (exc_cause[12]) exc_code = 5'd12;  // instr page fault
        else if (exc_cause[1])  exc_code = 5'd1;   // instr access fault
        else if (exc_cause[2])  exc_code = 5'd2;   // illegal instruction
        else if (exc_cause[0])  exc_code = 5'd0;   // instr misaligned
        else if (exc_cause[8])  exc_code = 5'd8;
        else if (exc_cause[9])  exc_code = 5'd9;
        else if (exc_cause[11]) exc_code = 5'd11;
        else if (exc_cause[4])  exc_code = 5'd4;
        else if (exc_cause[6])  exc_code = 5'd6;
        else if (exc_cause[13]) exc_code = 5'd13;
        else if (exc_cause[15]) exc_code = 5'd15;
        else if (exc_cause[5])  exc_code = 5'd5;
        else if (exc_cause[7])  exc_code = 5'd7;
    end

    always_comb begin
        irq_code = 4'd0;
        if      (pend[11]) irq_code = 4'd11;
        else if (pend[3])  irq_code = 4'd3;
        else if (pend[7])  irq_code = 4'd7;
        else if (pend[9])  irq_code = 4'd9;
        else if (pend[1])  irq_code = 4'd1;
        else if (pend[5])  irq_code = 4'd5;
        else if (pend[13]) irq_code = 4'd13;
    end

    // Only recognised sources can raise a trap, so the cause code is always defined.
    assign irq_any = pend[11] | pend[3] | pend[7] | pend[9] | pend[1] | pend[5] | pend[13];

    assign exc_take   = idle && commit_valid && (exc_cause != 20'd0);
    assign irq_take   = idle && commit_valid && !exc_take && mie_reg && irq_any;
    assign mret_take  = idle && commit_valid && !exc_take && !irq_take && mret;
    assign event_take = exc_take | irq_take | mret_take;

    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        trap_target = tvec_base;
        if (irq_take && (mtvec[1:0] == 2'b01))
            trap_target = tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (event_take) state_next = ST_FLUSH;
            ST_FLUSH:    if (flush_ack) state_next = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        flush          = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        case (state_reg)
            ST_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

    // CSR state and redirect target; a trap or MRET event takes precedence over a software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_reg         <= 1'b0;
            mpie_reg        <= 1'b0;
            mpp_reg         <= 2'b11;
            mepc_reg        <= '0;
            mcause_reg      <= '0;
            mtval_reg       <= '0;
            redirect_pc_reg <= '0;
        end else if (exc_take) begin
            mcause_reg      <= {{(XLEN-5){1'b0}}, exc_code};
            mepc_reg        <= {commit_pc[XLEN-1:2], 2'b00};
            mtval_reg       <= exc_tval;
            mpie_reg        <= mie_reg;
            mie_reg         <= 1'b0;
            mpp_reg         <= 2'b11;
            redirect_pc_reg <= trap_target;
        end else if (irq_take) begin
            mcause_reg      <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
            mepc_reg        <= commit_pc;
            mtval_reg       <= '0;
            mpie_reg        <= mie_reg;
            mie_reg         <= 1'b0;
            mpp_reg         <= 2'b11;
            redirect_pc_reg <= trap_target;
        end else if (mret_take) begin
            mie_reg         <= mpie_reg;
            mpie_reg        <= 1'b1;
            mpp_reg         <= 2'b11;
            redirect_pc_reg <= mepc_reg;
        end else if (idle && csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_reg  <= csr_wdata[3];
                    mpie_reg <= csr_wdata[7];
                    mpp_reg  <= 2'b11;  // M-only hart: every MPP value reads back as M
                end
                ADDR_MEPC:   mepc_reg   <= {csr_wdata[XLEN-1:2], 2'b00};
                ADDR_MCAUSE: mcause_reg <= csr_wdata;
                ADDR_MTVAL:  mtval_reg  <= csr_wdata;
                default: ;
            endcase
        end
    end

    assign redirect_pc  = redirect_pc_reg;
    assign mstatus_mie  = mie_reg;
    assign mstatus_mpie = mpie_reg;
    assign mstatus_mpp  = mpp_reg;
    assign mepc_o       = mepc_reg;
    assign mcause_o     = mcause_reg;
    assign mtval_o      = mtval_reg;

    assign unused_bits = ^{RESET_PC, pend[15:14], pend[12], pend[10], pend[8], pend[6],
                           pend[4], pend[2], pend[0], exc_cause[19:16], exc_cause[14],
                           exc_cause[10]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, priorities, vectoring, masking,
// MRET with redirect back-pressure, and reset during a flush.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [19:0] exc_cause;
    logic [31:0] exc_tval;
    logic        mret;
    logic [15:0] mip;
    logic [15:0] mie;
    logic [31:0] mtvec;
    logic        flush;
    logic        flush_ack;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [1:0]  mstatus_mpp;
    logic [31:0] mepc_o;
    logic [31:0] mcause_o;
    logic [31:0] mtval_o;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .mret           (mret),
        .mip            (mip),
        .mie            (mie),
        .mtvec          (mtvec),
        .flush          (flush),
        .flush_ack      (flush_ack),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .mstatus_mie    (mstatus_mie),
        .mstatus_mpie   (mstatus_mpie),
        .mstatus_mpp    (mstatus_mpp),
        .mepc_o         (mepc_o),
        .mcause_o       (mcause_o),
        .mtval_o        (mtval_o),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
        $display("csr write addr=%h data=%h", addr, data);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [19:0] cause,
                          input logic [31:0] tval, input logic is_mret);
        commit_valid = 1'b1;
        commit_pc    = pc;
        exc_cause    = cause;
        exc_tval     = tval;
        mret         = is_mret;
        tick();
        commit_valid = 1'b0;
        exc_cause    = '0;
        mret         = 1'b0;
        $display("commit pc=%h cause=%h mret=%0d -> mcause=%h busy=%0d", pc, cause, is_mret, mcause_o, busy);
    endtask

    // Acknowledge the flush, then accept the redirect; checks the state at each step.
    task automatic drain(input string tag);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        $display("drain %s done", tag);
    endtask

    initial begin
        rst = 1'b1; commit_valid = 0; commit_pc = 0; exc_cause = 0; exc_tval = 0;
        mret = 0; mip = 0; mie = 0; mtvec = 32'h800; flush_ack = 0; redirect_ready = 0;
        csr_we = 0; csr_addr = 0; csr_wdata = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_mpp",   {30'd0, mstatus_mpp}, 32'd3);
        chk("rst_mepc",  mepc_o, 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);

        // Illegal instruction with MIE=1
        csr_write(12'h300, 32'h8);
        chk("mie_set", {31'd0, mstatus_mie}, 32'd1);
        commit(32'h100, 20'h4, 32'hDEAD, 1'b0);
        chk("ii_mcause", mcause_o, 32'd2);
        chk("ii_mepc",   mepc_o, 32'h100);
        chk("ii_mtval",  mtval_o, 32'hDEAD);
        chk("ii_mie",    {31'd0, mstatus_mie}, 32'd0);
        chk("ii_mpie",   {31'd0, mstatus_mpie}, 32'd1);
        chk("ii_flush",  {31'd0, flush}, 32'd1);
        chk("ii_busy",   {31'd0, busy}, 32'd1);
        chk("ii_rpc",    redirect_pc, 32'h800);
        // Software write while busy is ignored
        csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55;
        tick();
        csr_we = 1'b0;
        chk("busy_wr_ignored", mcause_o, 32'd2);
        chk("ii_flush_hold", {31'd0, flush}, 32'd1);
        drain("ii");

        // Priority: BP beats II and LAF; exception beats pending MTI
        csr_write(12'h300, 32'h8);
        mip = 16'h0080; mie = 16'h0080;
        commit(32'h202, 20'h0002C, 32'h1234, 1'b0);
        chk("prio_mcause", mcause_o, 32'd3);
        chk("prio_mepc",   mepc_o, 32'h200);
        chk("prio_rpc",    redirect_pc, 32'h800);
        drain("prio");

        // Masked interrupt: no trap while MIE=0
        commit(32'h300, 20'h0, 32'h0, 1'b0);
        chk("mask_busy",   {31'd0, busy}, 32'd0);
        chk("mask_mcause", mcause_o, 32'd3);
        csr_write(12'h300, 32'h8);
        commit(32'h304, 20'h0, 32'h0, 1'b0);
        chk("mti_mcause", mcause_o, 32'h8000_0007);
        chk("mti_mepc",   mepc_o, 32'h304);
        chk("mti_mtval",  mtval_o, 32'h0);
        chk("mti_rpc",    redirect_pc, 32'h800);
        drain("mti");

        // Vectored interrupt: MEI beats MTI
        csr_write(12'h300, 32'h8);
        mtvec = 32'h801; mip = 16'h0880; mie = 16'h0880;
        commit(32'h400, 20'h0, 32'h0, 1'b0);
        chk("vec_mcause", mcause_o, 32'h8000_000B);
        chk("vec_rpc",    redirect_pc, 32'h82C);
        chk("vec_mepc",   mepc_o, 32'h400);
        drain("vec");

        // MRET with back-pressured redirect
        mip = 16'h0; mie = 16'h0; mtvec = 32'h800;
        csr_write(12'h341, 32'h207);
        chk("mepc_wr", mepc_o, 32'h204);
        csr_write(12'h300, 32'h1880);
        chk("mpp_coerce", {30'd0, mstatus_mpp}, 32'd3);
        commit(32'h500, 20'h0, 32'h0, 1'b1);
        chk("mret_mie",  {31'd0, mstatus_mie}, 32'd1);
        chk("mret_mpie", {31'd0, mstatus_mpie}, 32'd1);
        chk("mret_rpc",  redirect_pc, 32'h204);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv",   {31'd0, redirect_valid}, 32'd1);
            chk("bp_rpc",  redirect_pc, 32'h204);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("mret_done", {31'd0, busy}, 32'd0);

        // Reset in FLUSH
        commit(32'h600, 20'h1, 32'h0, 1'b0);
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_flush", {31'd0, flush}, 32'd0);
        chk("midrst_busy",  {31'd0, busy}, 32'd0);
        chk("midrst_rv",    {31'd0, redirect_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
